// File: rtl/exc_ctrl_pkg.sv
// Exception controller shared types: event kinds, FSM states,
// CP0 STATUS/CAUSE field positions and default vector.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  localparam int FLUSH_CYCLES_DEF = 2;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int CA_IP_LO = 8;
  localparam int CA_IP_HI = 9;

  typedef enum logic [2:0] {
    EXC_NONE,
    EXC_INT,
    EXC_ADEL,
    EXC_ADES,
    EXC_OV,
    EXC_SYS,
    EXC_BP,
    EXC_ERET
  } exc_kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_BLOCK
  } exc_state_e;

  function automatic exc_kind_e exc_pick(
    input logic intr,
    input logic adel,
    input logic ades,
    input logic ov,
    input logic sys,
    input logic bp,
    input logic eret
  );
    exc_kind_e k;
    k = EXC_NONE;
    if (intr)      k = EXC_INT;
    else if (adel) k = EXC_ADEL;
    else if (ades) k = EXC_ADES;
    else if (ov)   k = EXC_OV;
    else if (sys)  k = EXC_SYS;
    else if (bp)   k = EXC_BP;
    else if (eret) k = EXC_ERET;
    return k;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage event bundle in, CP0 update pulses and
// fetch redirect out.
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_delayslot_i;
  logic        mem_syscall_i;
  logic        mem_break_i;
  logic        mem_overflow_i;
  logic        mem_eret_i;
  logic        mem_adel_i;
  logic        mem_ades_i;
  logic [31:0] mem_badaddr_i;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;

  logic        int_flag_o;
  logic        eret_flag_o;
  logic        syscall_flag_o;
  logic        break_flag_o;
  logic        overflow_flag_o;
  logic        address_read_error_flag_o;
  logic        address_write_error_flag_o;
  logic        delayslot_flag_o;
  logic [31:0] current_pc_addr_o;
  logic [31:0] badvaddr_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  modport slave (
    input  mem_valid_i, mem_stall_i, mem_pc_i,
    input  mem_delayslot_i, mem_syscall_i,
    input  mem_break_i, mem_overflow_i, mem_eret_i,
    input  mem_adel_i, mem_ades_i, mem_badaddr_i,
    input  int_i, timer_int_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    output int_flag_o, eret_flag_o, syscall_flag_o,
    output break_flag_o, overflow_flag_o,
    output address_read_error_flag_o,
    output address_write_error_flag_o,
    output delayslot_flag_o, current_pc_addr_o,
    output badvaddr_o, flush_o,
    output redirect_valid_o, redirect_pc_o
  );

  modport master (
    output mem_valid_i, mem_stall_i, mem_pc_i,
    output mem_delayslot_i, mem_syscall_i,
    output mem_break_i, mem_overflow_i, mem_eret_i,
    output mem_adel_i, mem_ades_i, mem_badaddr_i,
    output int_i, timer_int_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  int_flag_o, eret_flag_o, syscall_flag_o,
    input  break_flag_o, overflow_flag_o,
    input  address_read_error_flag_o,
    input  address_write_error_flag_o,
    input  delayslot_flag_o, current_pc_addr_o,
    input  badvaddr_o, flush_o,
    input  redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchronizer for the hardware interrupt lines.
module exc_int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter: one event per window,
// CP0 update pulses, pipeline flush and fetch redirect.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  exc_state_e state;
  logic [CW-1:0] cnt;
  logic [5:0] hw_raw;
  logic [5:0] hw_pend;
  logic [7:0] ip;
  logic [7:0] im;
  logic int_req;
  exc_kind_e kind;
  logic accept;

  assign hw_raw = {bus.int_i[5] | bus.timer_int_i,
                   bus.int_i[4:0]};

  exc_int_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_raw),
    .q   (hw_pend)
  );

  assign ip = {hw_pend,
               bus.cp0_cause_i[CA_IP_HI:CA_IP_LO]};
  assign im = bus.cp0_status_i[ST_IM_HI:ST_IM_LO];

  assign int_req = bus.cp0_status_i[ST_IE]
                 & ~bus.cp0_status_i[ST_EXL]
                 & (|(ip & im));

  assign kind = exc_pick(int_req,
                         bus.mem_adel_i,
                         bus.mem_ades_i,
                         bus.mem_overflow_i,
                         bus.mem_syscall_i,
                         bus.mem_break_i,
                         bus.mem_eret_i);

  assign accept = (state == S_IDLE)
                & bus.mem_valid_i
                & ~bus.mem_stall_i
                & (kind != EXC_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                          <= S_IDLE;
      cnt                            <= '0;
      bus.flush_o                    <= 1'b0;
      bus.int_flag_o                 <= 1'b0;
      bus.eret_flag_o                <= 1'b0;
      bus.syscall_flag_o             <= 1'b0;
      bus.break_flag_o               <= 1'b0;
      bus.overflow_flag_o            <= 1'b0;
      bus.address_read_error_flag_o  <= 1'b0;
      bus.address_write_error_flag_o <= 1'b0;
      bus.delayslot_flag_o           <= 1'b0;
      bus.current_pc_addr_o          <= '0;
      bus.badvaddr_o                 <= '0;
      bus.redirect_valid_o           <= 1'b0;
      bus.redirect_pc_o              <= '0;
    end else begin
      // pulse outputs live for exactly one cycle after accept
      bus.int_flag_o                 <= 1'b0;
      bus.eret_flag_o                <= 1'b0;
      bus.syscall_flag_o             <= 1'b0;
      bus.break_flag_o               <= 1'b0;
      bus.overflow_flag_o            <= 1'b0;
      bus.address_read_error_flag_o  <= 1'b0;
      bus.address_write_error_flag_o <= 1'b0;
      bus.delayslot_flag_o           <= 1'b0;
      bus.current_pc_addr_o          <= '0;
      bus.badvaddr_o                 <= '0;
      bus.redirect_valid_o           <= 1'b0;
      bus.redirect_pc_o              <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state                <= S_FLUSH;
            cnt                  <= CNT_INIT;
            bus.flush_o          <= 1'b1;
            bus.int_flag_o       <= (kind == EXC_INT);
            bus.eret_flag_o      <= (kind == EXC_ERET);
            bus.syscall_flag_o   <= (kind == EXC_SYS);
            bus.break_flag_o     <= (kind == EXC_BP);
            bus.overflow_flag_o  <= (kind == EXC_OV);
            bus.address_read_error_flag_o  <= (kind == EXC_ADEL);
            bus.address_write_error_flag_o <= (kind == EXC_ADES);
            bus.delayslot_flag_o  <= bus.mem_delayslot_i;
            bus.current_pc_addr_o <= bus.mem_pc_i;
            bus.badvaddr_o <=
              (kind == EXC_ADEL || kind == EXC_ADES)
                ? bus.mem_badaddr_i : 32'h0;
            bus.redirect_valid_o <= 1'b1;
            bus.redirect_pc_o <= (kind == EXC_ERET)
                                 ? bus.cp0_epc_i : EXC_VECTOR;
          end
        end
        S_FLUSH: begin
          if (cnt == '0) begin
            state       <= S_BLOCK;
            bus.flush_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_BLOCK: state <= S_IDLE;
        default: begin
          state       <= S_IDLE;
          bus.flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: arbitration, latency,
// stall, flush window and mid-flush reset.
module tb_exc_ctrl;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_ctrl_if bus ();

  exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_INT  = 7'b1000000;
  localparam logic [6:0] F_ADEL = 7'b0100000;
  localparam logic [6:0] F_OV   = 7'b0001000;
  localparam logic [6:0] F_SYS  = 7'b0000100;
  localparam logic [6:0] F_ERET = 7'b0000001;
  localparam logic [31:0] VEC   = 32'hBFC00380;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag,
                           input logic [6:0] exp);
    logic [6:0] obs;
    obs = {bus.int_flag_o,
           bus.address_read_error_flag_o,
           bus.address_write_error_flag_o,
           bus.overflow_flag_o,
           bus.syscall_flag_o,
           bus.break_flag_o,
           bus.eret_flag_o};
    chk(tag, {25'h0, obs}, {25'h0, exp});
  endtask

  task automatic clr_ev();
    bus.mem_valid_i     = 1'b0;
    bus.mem_stall_i     = 1'b0;
    bus.mem_delayslot_i = 1'b0;
    bus.mem_syscall_i   = 1'b0;
    bus.mem_break_i     = 1'b0;
    bus.mem_overflow_i  = 1'b0;
    bus.mem_eret_i      = 1'b0;
    bus.mem_adel_i      = 1'b0;
    bus.mem_ades_i      = 1'b0;
    bus.mem_badaddr_i   = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clr_ev();
    bus.mem_pc_i     = 32'h0;
    bus.int_i        = 6'h0;
    bus.timer_int_i  = 1'b0;
    bus.cp0_status_i = 32'h0;
    bus.cp0_cause_i  = 32'h0;
    bus.cp0_epc_i    = 32'h0;
    step(2);
    chk_flags("rst_flags", F_NONE);
    chk("rst_flush", {31'h0, bus.flush_o}, 32'h0);
    chk("rst_rv", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("rst_rpc", bus.redirect_pc_o, 32'h0);
    chk("rst_pc", bus.current_pc_addr_o, 32'h0);
    chk("rst_bad", bus.badvaddr_o, 32'h0);
    rst = 1'b0;

    // syscall, flush window length
    bus.cp0_status_i  = 32'h0040FF01;
    bus.mem_valid_i   = 1'b1;
    bus.mem_pc_i      = 32'h80001000;
    bus.mem_syscall_i = 1'b1;
    step();
    chk_flags("sys_flags", F_SYS);
    chk("sys_pc", bus.current_pc_addr_o, 32'h80001000);
    chk("sys_rpc", bus.redirect_pc_o, VEC);
    chk("sys_rv", {31'h0, bus.redirect_valid_o}, 32'h1);
    chk("sys_fl1", {31'h0, bus.flush_o}, 32'h1);
    chk("sys_ds", {31'h0, bus.delayslot_flag_o}, 32'h0);
    clr_ev();
    step();
    chk_flags("sys_t2", F_NONE);
    chk("sys_rv2", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("sys_fl2", {31'h0, bus.flush_o}, 32'h1);
    step();
    chk("sys_fl3", {31'h0, bus.flush_o}, 32'h0);
    step();

    // hw interrupt 0 enabled through IM2: 3-cycle latency
    bus.cp0_status_i = 32'h00000401;
    bus.mem_valid_i  = 1'b1;
    bus.mem_pc_i     = 32'h80001100;
    bus.int_i        = 6'b000001;
    step();
    chk_flags("int_c1", F_NONE);
    step();
    chk_flags("int_c2", F_NONE);
    step();
    chk_flags("int_c3", F_INT);
    chk("int_pc", bus.current_pc_addr_o, 32'h80001100);
    bus.int_i = 6'h0;
    clr_ev();
    step(3);

    // EXL masks interrupts entirely
    bus.cp0_status_i = 32'h00000403;
    bus.mem_valid_i  = 1'b1;
    bus.int_i        = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_flags("exl_nopulse", F_NONE);
    end
    chk("exl_fl", {31'h0, bus.flush_o}, 32'h0);
    bus.int_i = 6'h0;
    clr_ev();
    step(3);

    // overflow beats break, delay slot reported
    bus.cp0_status_i    = 32'h0040FF01;
    bus.mem_valid_i     = 1'b1;
    bus.mem_pc_i        = 32'h80002004;
    bus.mem_delayslot_i = 1'b1;
    bus.mem_overflow_i  = 1'b1;
    bus.mem_break_i     = 1'b1;
    step();
    chk_flags("ov_flags", F_OV);
    chk("ov_ds", {31'h0, bus.delayslot_flag_o}, 32'h1);
    chk("ov_pc", bus.current_pc_addr_o, 32'h80002004);
    chk("ov_bad", bus.badvaddr_o, 32'h0);
    clr_ev();
    step(3);

    // eret, then a syscall during FLUSH is dropped
    bus.cp0_epc_i   = 32'h80003000;
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = 32'h80002100;
    bus.mem_eret_i  = 1'b1;
    step();
    chk_flags("eret_flags", F_ERET);
    chk("eret_rpc", bus.redirect_pc_o, 32'h80003000);
    bus.mem_eret_i    = 1'b0;
    bus.mem_syscall_i = 1'b1;
    step();
    chk_flags("eret_sys_ign", F_NONE);
    chk("eret_rv", {31'h0, bus.redirect_valid_o}, 32'h0);
    clr_ev();
    step(2);

    // AdEL held off by stall
    bus.mem_valid_i   = 1'b1;
    bus.mem_pc_i      = 32'h80002200;
    bus.mem_adel_i    = 1'b1;
    bus.mem_badaddr_i = 32'h80000003;
    bus.mem_stall_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_flags("stall_nopulse", F_NONE);
    end
    bus.mem_stall_i = 1'b0;
    step();
    chk_flags("adel_flags", F_ADEL);
    chk("adel_bad", bus.badvaddr_o, 32'h80000003);
    chk("adel_pc", bus.current_pc_addr_o, 32'h80002200);
    clr_ev();
    step(3);

    // software interrupt and syscall together: int wins
    bus.cp0_status_i  = 32'h00000101;
    bus.cp0_cause_i   = 32'h00000100;
    bus.mem_valid_i   = 1'b1;
    bus.mem_pc_i      = 32'h80006000;
    bus.mem_syscall_i = 1'b1;
    step();
    chk_flags("intsys_flags", F_INT);
    chk("intsys_pc", bus.current_pc_addr_o, 32'h80006000);
    chk("intsys_rpc", bus.redirect_pc_o, VEC);
    clr_ev();
    bus.cp0_cause_i = 32'h0;
    step(3);

    // timer interrupt via IM7
    bus.cp0_status_i = 32'h00008001;
    bus.mem_valid_i  = 1'b1;
    bus.timer_int_i  = 1'b1;
    step(2);
    chk_flags("tmr_c2", F_NONE);
    step();
    chk_flags("tmr_c3", F_INT);
    bus.timer_int_i = 1'b0;
    clr_ev();
    step(3);

    // reset while flushing
    bus.cp0_status_i  = 32'h0040FF01;
    bus.mem_valid_i   = 1'b1;
    bus.mem_pc_i      = 32'h80004000;
    bus.mem_syscall_i = 1'b1;
    step();
    chk_flags("rstf_acc", F_SYS);
    clr_ev();
    rst = 1'b1;
    step();
    chk("rstf_fl", {31'h0, bus.flush_o}, 32'h0);
    chk_flags("rstf_flags", F_NONE);
    chk("rstf_rv", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("rstf_pc", bus.current_pc_addr_o, 32'h0);
    rst = 1'b0;
    bus.mem_valid_i   = 1'b1;
    bus.mem_pc_i      = 32'h80005000;
    bus.mem_syscall_i = 1'b1;
    step();
    chk_flags("rstf_new", F_SYS);
    chk("rstf_newpc", bus.current_pc_addr_o, 32'h80005000);
    chk("rstf_newfl", {31'h0, bus.flush_o}, 32'h1);
    clr_ev();
    step(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
